// File: rtl/ignition_interlock_if.sv
// Signal bundle between the ignition interlock and the vehicle-side logic.
// master drives the sensor and driver inputs; slave is the interlock.
interface ignition_interlock_if #(
  parameter int unsigned NCH = 8
);
  logic           key;
  logic           brk;
  logic           pbrk;
  logic           srv;
  logic           bat_ok;
  logic           start_req;
  logic           eng_run;
  logic           ack;
  logic [NCH-1:0] sns_ok;
  logic [NCH-1:0] pri_mask;
  logic [NCH-1:0] warn;
  logic           warn_pri1;
  logic           warn_pri2;
  logic           chime;
  logic           start_permit;
  logic           crank;
  logic [2:0]     state;

  modport master (
    output key, brk, pbrk, srv, bat_ok, start_req, eng_run, ack, sns_ok, pri_mask,
    input  warn, warn_pri1, warn_pri2, chime, start_permit, crank, state
  );

  modport slave (
    input  key, brk, pbrk, srv, bat_ok, start_req, eng_run, ack, sns_ok, pri_mask,
    output warn, warn_pri1, warn_pri2, chime, start_permit, crank, state
  );
endinterface

// File: rtl/ignition_interlock.sv
// Ignition interlock: per-channel sensor debounce, prioritised warning chime
// with driver acknowledge, and the key/start/crank/lockout state machine.
module ignition_interlock #(
  parameter int unsigned NCH       = 8,
  parameter int unsigned DEB_N     = 10,
  parameter int unsigned CHIME_ON  = 16,
  parameter int unsigned CHIME_OFF = 16,
  parameter int unsigned CRANK_MAX = 64,
  parameter int unsigned LOCK_CYC  = 128
) (
  input logic                clk,
  input logic                rst,
  ignition_interlock_if.slave bus
);
  localparam int unsigned CW   = $clog2(DEB_N + 1);
  localparam int unsigned PER  = CHIME_ON + CHIME_OFF;
  localparam int unsigned PW   = $clog2(PER + 1);
  localparam int unsigned TMAX = (CRANK_MAX > LOCK_CYC) ? CRANK_MAX : LOCK_CYC;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_ARMED    = 3'd1,
    S_CRANKING = 3'd2,
    S_RUN      = 3'd3,
    S_LOCKOUT  = 3'd4
  } state_t;

  logic [NCH-1:0] warn, warn_d;
  logic [CW-1:0]  deb_cnt   [NCH];
  logic [CW-1:0]  deb_cnt_d [NCH];

  always_comb begin
    warn_d = warn;
    for (int unsigned i = 0; i < NCH; i++) begin
      deb_cnt_d[i] = '0;
      if (~bus.sns_ok[i] != warn[i]) begin
        if (deb_cnt[i] == CW'(DEB_N - 1)) warn_d[i] = ~bus.sns_ok[i];
        else                              deb_cnt_d[i] = deb_cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      warn <= '0;
      for (int unsigned i = 0; i < NCH; i++) deb_cnt[i] <= '0;
    end else begin
      warn <= warn_d;
      for (int unsigned i = 0; i < NCH; i++) deb_cnt[i] <= deb_cnt_d[i];
    end
  end

  logic warn_pri1, warn_pri2, pri2_rise, ack_flag, chime_act;
  logic [PW-1:0] phase;

  assign warn_pri1 = (|(warn & bus.pri_mask))  & ~bus.srv;
  assign warn_pri2 = (|(warn & ~bus.pri_mask)) & ~bus.srv;
  // A fresh priority-2 fault re-arms the chime even if ACK is held on that edge.
  assign pri2_rise = |(warn_d & ~warn & ~bus.pri_mask);
  assign chime_act = warn_pri1 | (warn_pri2 & ~ack_flag);

  always_ff @(posedge clk) begin
    if (rst)                          ack_flag <= 1'b0;
    else if (pri2_rise || !warn_pri2) ack_flag <= 1'b0;
    else if (bus.ack)                 ack_flag <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || !chime_act)          phase <= '0;
    else if (phase == PW'(PER - 1)) phase <= '0;
    else                            phase <= phase + PW'(1);
  end

  state_t        state, state_d;
  logic [TW-1:0] tmr, tmr_d;
  logic          permit;

  assign permit = bus.key & ((bus.bat_ok & bus.brk & bus.pbrk & ~warn_pri1) | bus.srv);

  always_comb begin
    state_d = state;
    tmr_d   = '0;
    unique case (state)
      S_OFF:      if (bus.key) state_d = S_ARMED;
      S_ARMED:    if (bus.start_req && permit) state_d = S_CRANKING;
      S_CRANKING: begin
        if (bus.eng_run)                     state_d = S_RUN;
        else if (!bus.start_req)             state_d = S_ARMED;
        else if (tmr == TW'(CRANK_MAX - 1))  state_d = S_LOCKOUT;
      end
      S_RUN:      state_d = S_RUN;
      S_LOCKOUT:  if (tmr == TW'(LOCK_CYC - 1)) state_d = S_ARMED;
      default:    state_d = S_OFF;
    endcase
    if (!bus.key) state_d = S_OFF;
    if (state_d == state && (state == S_CRANKING || state == S_LOCKOUT))
      tmr_d = tmr + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_OFF;
      tmr   <= '0;
    end else begin
      state <= state_d;
      tmr   <= tmr_d;
    end
  end

  assign bus.warn         = warn;
  assign bus.warn_pri1    = warn_pri1;
  assign bus.warn_pri2    = warn_pri2;
  assign bus.chime        = chime_act & (phase < PW'(CHIME_ON)) & ~bus.srv;
  assign bus.start_permit = permit & (state == S_ARMED);
  assign bus.crank        = (state == S_CRANKING);
  assign bus.state        = state;
endmodule

// File: tb/tb_ignition_interlock.sv
// Bench for ignition_interlock: directed scenarios with literal expectations
// followed by randomized traffic compared each cycle against a behavioural model.
module tb_ignition_interlock;
  localparam int NCH       = 8;
  localparam int DEB_N     = 10;
  localparam int CHIME_ON  = 16;
  localparam int CHIME_OFF = 16;
  localparam int CRANK_MAX = 64;
  localparam int LOCK_CYC  = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ignition_interlock_if #(.NCH(NCH)) bus();

  ignition_interlock #(
    .NCH(NCH), .DEB_N(DEB_N), .CHIME_ON(CHIME_ON), .CHIME_OFF(CHIME_OFF),
    .CRANK_MAX(CRANK_MAX), .LOCK_CYC(LOCK_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Model: WARN flips once the last DEB_N raw samples all contradict it.
  logic [NCH-1:0] m_warn;
  logic [NCH-1:0] m_hist[$];
  bit             m_ack;
  int             m_run;     // consecutive active chime cycles before this one
  int             m_state;   // 0 OFF, 1 ARMED, 2 CRANKING, 3 RUN, 4 LOCKOUT
  int             m_cycles;  // cycles spent in current state, 1 on entry

  function automatic bit m_wp1();
    return (|(m_warn & bus.pri_mask)) && !bus.srv;
  endfunction
  function automatic bit m_wp2();
    return (|(m_warn & ~bus.pri_mask)) && !bus.srv;
  endfunction
  function automatic bit m_active();
    return m_wp1() || (m_wp2() && !m_ack);
  endfunction
  function automatic bit m_chime();
    return m_active() && !bus.srv && ((m_run % (CHIME_ON + CHIME_OFF)) < CHIME_ON);
  endfunction
  function automatic bit m_permit();
    return bus.key && ((bus.bat_ok && bus.brk && bus.pbrk && !m_wp1()) || bus.srv);
  endfunction
  function automatic bit m_start_permit();
    return m_permit() && (m_state == 1);
  endfunction
  function automatic bit m_crank();
    return m_state == 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                     input logic [31:0] exp);
    check(name, dut_v, exp);
    check({name, "_model"}, mdl_v, exp);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_warn   = '0;
      m_hist.delete();
      m_ack    = 1'b0;
      m_run    = 0;
      m_state  = 0;
      m_cycles = 1;
    end else begin
      bit             wp2_old, act_old, permit_old, all_bad;
      logic [NCH-1:0] new_warn;
      int             nxt;
      wp2_old    = m_wp2();
      act_old    = m_active();
      permit_old = m_permit();

      new_warn = m_warn;
      m_hist.push_back(bus.sns_ok);
      if (m_hist.size() > DEB_N) m_hist.delete(0);
      if (m_hist.size() == DEB_N) begin
        for (int i = 0; i < NCH; i++) begin
          all_bad = 1'b1;
          foreach (m_hist[j]) if (m_hist[j][i] != m_warn[i]) all_bad = 1'b0;
          if (all_bad) new_warn[i] = ~m_warn[i];
        end
      end

      if (|(new_warn & ~m_warn & ~bus.pri_mask)) m_ack = 1'b0;
      else if (!wp2_old)                         m_ack = 1'b0;
      else if (bus.ack)                          m_ack = 1'b1;

      m_run = act_old ? m_run + 1 : 0;

      nxt = m_state;
      case (m_state)
        0: if (bus.key) nxt = 1;
        1: if (bus.start_req && permit_old) nxt = 2;
        2: if (bus.eng_run) nxt = 3;
           else if (!bus.start_req) nxt = 1;
           else if (m_cycles >= CRANK_MAX) nxt = 4;
        4: if (m_cycles >= LOCK_CYC) nxt = 1;
        default: ;
      endcase
      if (!bus.key) nxt = 0;
      if (nxt != m_state) m_cycles = 1;
      else                m_cycles++;
      m_state = nxt;
      m_warn  = new_warn;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("state", {29'd0, bus.state}, m_state);
      check("warn", {24'd0, bus.warn}, {24'd0, m_warn});
      check("flags",
            {27'd0, bus.warn_pri1, bus.warn_pri2, bus.chime, bus.start_permit, bus.crank},
            {27'd0, m_wp1(), m_wp2(), m_chime(), m_start_permit(), m_crank()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [NCH-1:0] s;
    rst           = 1'b1;
    bus.key       = 1'b0;
    bus.brk       = 1'b0;
    bus.pbrk      = 1'b0;
    bus.srv       = 1'b0;
    bus.bat_ok    = 1'b0;
    bus.start_req = 1'b0;
    bus.eng_run   = 1'b0;
    bus.ack       = 1'b0;
    bus.sns_ok    = '1;
    bus.pri_mask  = 8'h01;
    tick();
    tick();
    chk_en = 1'b1;
    lit("rst_state", bus.state, m_state, 0);
    lit("rst_warn", bus.warn, m_warn, 0);
    lit("rst_chime", bus.chime, m_chime(), 0);
    lit("rst_crank", bus.crank, m_crank(), 0);
    rst = 1'b0;

    // Debounce boundary: 9 bad samples are a glitch, 10 are a fault.
    bus.sns_ok = 8'hFE;
    repeat (9) tick();
    bus.sns_ok = 8'hFF;
    tick();
    lit("glitch9_warn", bus.warn, m_warn, 0);
    bus.sns_ok = 8'hFE;
    repeat (9) tick();
    lit("deb9_warn", bus.warn, m_warn, 0);
    tick();
    lit("deb10_warn", bus.warn, m_warn, 8'h01);
    lit("pri1", bus.warn_pri1, m_wp1(), 1);

    bus.ack = 1'b1;
    for (int k = 0; k < 32; k++) begin
      lit($sformatf("chime_p1_%0d", k), bus.chime, m_chime(), (k < 16) ? 1 : 0);
      tick();
    end
    lit("chime_p1_wrap", bus.chime, m_chime(), 1);
    bus.ack = 1'b0;
    bus.srv = 1'b1;
    tick();
    lit("srv_chime", bus.chime, m_chime(), 0);
    lit("srv_pri1", bus.warn_pri1, m_wp1(), 0);
    bus.srv = 1'b0;
    bus.sns_ok = 8'hFF;
    repeat (10) tick();
    lit("clear0_warn", bus.warn, m_warn, 0);

    // Priority-2 fault, acknowledge, then a second priority-2 fault re-arms.
    bus.sns_ok = 8'hF7;
    repeat (10) tick();
    lit("ch3_warn", bus.warn, m_warn, 8'h08);
    lit("ch3_pri2", bus.warn_pri2, m_wp2(), 1);
    lit("ch3_chime", bus.chime, m_chime(), 1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    lit("ack_chime", bus.chime, m_chime(), 0);
    bus.sns_ok = 8'hE7;
    repeat (9) tick();
    lit("acked_chime", bus.chime, m_chime(), 0);
    tick();
    lit("ch4_warn", bus.warn, m_warn, 8'h18);
    lit("ch4_chime", bus.chime, m_chime(), 1);
    bus.sns_ok = 8'hFF;
    repeat (10) tick();
    lit("clear34_warn", bus.warn, m_warn, 0);

    // Normal start.
    bus.key = 1'b1; bus.brk = 1'b1; bus.pbrk = 1'b1; bus.bat_ok = 1'b1;
    tick();
    lit("armed", bus.state, m_state, 1);
    lit("armed_permit", bus.start_permit, m_start_permit(), 1);
    bus.start_req = 1'b1;
    tick();
    lit("cranking", bus.state, m_state, 2);
    lit("crank_out", bus.crank, m_crank(), 1);
    repeat (4) tick();
    bus.eng_run = 1'b1;
    tick();
    lit("run", bus.state, m_state, 3);
    lit("run_crank", bus.crank, m_crank(), 0);
    bus.start_req = 1'b0;
    bus.eng_run   = 1'b0;
    bus.key       = 1'b0;
    tick();
    lit("key_drop_off", bus.state, m_state, 0);

    // Crank timeout into lockout and back to armed.
    bus.key = 1'b1;
    tick();
    bus.start_req = 1'b1;
    tick();
    lit("to_crank", bus.state, m_state, 2);
    repeat (63) tick();
    lit("crank63", bus.state, m_state, 2);
    tick();
    lit("lockout", bus.state, m_state, 4);
    lit("lock_permit", bus.start_permit, m_start_permit(), 0);
    lit("lock_crank", bus.crank, m_crank(), 0);
    repeat (127) tick();
    lit("lock127", bus.state, m_state, 4);
    tick();
    lit("lock_done", bus.state, m_state, 1);
    lit("rearm_permit", bus.start_permit, m_start_permit(), 1);
    tick();
    repeat (64) tick();
    lit("lockout2", bus.state, m_state, 4);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lit("rst_in_lock", bus.state, m_state, 0);
    tick();
    lit("rst_rearm", bus.state, m_state, 1);
    tick();
    repeat (63) tick();
    lit("fresh_crank63", bus.state, m_state, 2);
    tick();
    lit("fresh_lockout", bus.state, m_state, 4);
    bus.key = 1'b0;
    bus.start_req = 1'b0;
    tick();
    lit("key_off_lock", bus.state, m_state, 0);

    // Randomized traffic.
    bus.key = 1'b1;
    bus.pri_mask = 8'h05;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      rst = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 299) == 0) bus.key = ~bus.key;
      if ($urandom_range(0, 39) == 0) bus.brk    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) bus.pbrk   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) bus.bat_ok = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 599) == 0) bus.srv = ~bus.srv;
      if ($urandom_range(0, 69) == 0) bus.start_req = ~bus.start_req;
      if ($urandom_range(0, 59) == 0) bus.eng_run = ~bus.eng_run;
      bus.ack = ($urandom_range(0, 15) == 0);
      s = bus.sns_ok;
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 49) == 0) s[i] = ~s[i];
      bus.sns_ok = s;
      tick();
    end
    rst = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ignition_interlock.md
IGNITION_INTERLOCK -- requirements
Module: ignition_interlock

Interface
REQ-001 Parameter NCH, default 8, number of sensor channels (2..32).
REQ-002 Parameter DEB_N, default 10, debounce cycles (1..255).
REQ-003 Parameter CHIME_ON, default 16, chime high cycles per period.
REQ-004 Parameter CHIME_OFF, default 16, chime low cycles per period.
REQ-005 Parameter CRANK_MAX, default 64, max crank cycles before lockout.
REQ-006 Parameter LOCK_CYC, default 128, lockout duration in cycles.
REQ-007 CLK  in  1  sole clock; all state updates on rising edge.
REQ-008 RST  in  1  reset, synchronous, active-high.
REQ-009 KEY, BRK, PBRK, SRV, BAT_OK, START_REQ, ENG_RUN, ACK  in  1 each  key on, brake, parking brake, service mode, battery ok, start button, engine-running feedback, driver acknowledge.
REQ-010 SNS_OK  in  NCH  raw sensor status, 1 = ok.
REQ-011 PRI_MASK  in  NCH  1 = channel is priority-1, 0 = priority-2; static during operation.
REQ-012 WARN  out  NCH  debounced warning per channel.
REQ-013 WARN_PRI1, WARN_PRI2, CHIME, START_PERMIT, CRANK  out  1 each.
REQ-014 STATE  out  3  FSM state encoding: OFF=0, ARMED=1, CRANKING=2, RUN=3, LOCKOUT=4.

Function
REQ-015 Each channel SHALL keep a registered WARN bit and a counter of width clog2(DEB_N+1).
REQ-016 While ~SNS_OK[i] equals WARN[i], counter i SHALL be 0; while different, it SHALL increment each cycle.
REQ-017 When counter i reaches DEB_N-1 and disagreement persists that cycle, WARN[i] SHALL take ~SNS_OK[i] on that edge (change visible exactly DEB_N cycles after the first disagreeing sample) and the counter SHALL clear.
REQ-018 A single agreeing sample SHALL clear counter i; glitches shorter than DEB_N cycles SHALL never change WARN.
REQ-019 WARN_PRI1 = |(WARN & PRI_MASK) & ~SRV; WARN_PRI2 = |(WARN & ~PRI_MASK) & ~SRV; both combinational from registered WARN.
REQ-020 Chime phase counter SHALL run only while (WARN_PRI1 | unacked-PRI2); CHIME high for CHIME_ON cycles then low for CHIME_OFF cycles, repeating, starting high on the first cycle of activity; counter SHALL clear to 0 when inactive.
REQ-021 ACK high while WARN_PRI2 SHALL set an ack flag one cycle later, silencing PRI2 chime contribution.
REQ-022 Ack flag SHALL clear when WARN_PRI2 falls, or when any priority-2 WARN bit rises (new fault); rise beats simultaneous ACK.
REQ-023 ACK SHALL never silence WARN_PRI1 chime; SRV=1 SHALL force CHIME=0.
REQ-024 permit = KEY & ((BAT_OK & BRK & PBRK & ~WARN_PRI1) | SRV); START_PERMIT = permit & (STATE==ARMED).
REQ-025 KEY=0 SHALL force next state OFF from any state (highest priority).
REQ-026 OFF->ARMED when KEY=1.
REQ-027 ARMED->CRANKING when START_REQ & permit.
REQ-028 CRANKING: CRANK=1; ->RUN when ENG_RUN=1; ->ARMED when START_REQ=0; ->LOCKOUT after CRANK_MAX cycles in CRANKING without ENG_RUN; priority ENG_RUN > START_REQ release > timeout.
REQ-029 RUN: CRANK=0; remain until KEY=0.
REQ-030 LOCKOUT: START_PERMIT=0, CRANK=0; ->ARMED after exactly LOCK_CYC cycles; START_REQ ignored.
REQ-031 One shared state-timer SHALL clear on every state transition.

Reset
REQ-032 RST=1 on an edge SHALL set STATE=OFF, WARN=0, all counters 0, ack flag 0; CHIME, CRANK, START_PERMIT, WARN_PRI1, WARN_PRI2 read 0 the following cycle.
REQ-033 RST mid-crank or mid-lockout SHALL abort immediately to OFF with no residual timer.

Verification
REQ-034 SNS_OK[0] low 9 cycles then high (DEB_N=10) -> WARN[0] stays 0; low 10 cycles -> WARN[0]=1 on 10th edge.
REQ-035 PRI_MASK=0x01, channel 0 fault -> WARN_PRI1=1, CHIME 16 high/16 low, ACK has no effect; SRV=1 -> CHIME=0.
REQ-036 Channel 3 (PRI2) fault, ACK -> CHIME 0; channel 4 then faults -> chime restarts high.
REQ-037 KEY, BRK, PBRK, BAT_OK=1, START_REQ=1, ENG_RUN after 5 cycles -> OFF->ARMED->CRANKING(CRANK=1)->RUN.
REQ-038 CRANKING with ENG_RUN=0 for 64 cycles -> LOCKOUT 128 cycles, START_PERMIT=0, then ARMED.
REQ-039 KEY drop in RUN, and RST asserted in LOCKOUT -> STATE=OFF next cycle.
